n4_layer_sequencer: RTL and testbench
=====================================

Name: n4_layer_sequencer

Overview:
- Top-level scheduler for the n4 inference pipeline. It runs NUM_LAYERS layer engines, such as the dense layers, strictly in order.
- Each layer engine takes a level-sensitive enable, which clears its counters while low. It raises a work-finished flag when all of its outputs have been written.
- The sequencer drives one enable at a time and inserts a clear gap between layers. It toggles the ping-pong activation-buffer select between layers and guards each layer with a watchdog.

Parameters:
- NUM_LAYERS, 4, number of layer engines sequenced (1..15).
- IDLE_GAP, 2, cycles all enables are held low before each layer starts (>=1; lets engine counters clear).
- TIMEOUT, 65535, maximum cycles a layer may stay enabled before the error state.
- TO_W, 16, watchdog counter width (must hold TIMEOUT).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, 1-cycle request to run the whole network; honoured only in IDLE.
- abort, in, 1, level; forces IDLE from any state.
- layer_done, in, NUM_LAYERS, work-finished flags, bit i from layer i.
- layer_en, out, NUM_LAYERS, one-hot (or zero) enables, registered.
- buf_sel, out, 1, ping-pong bank: current layer reads bank buf_sel and writes bank ~buf_sel.
- cur_layer, out, 4, index of the layer in progress.
- busy, out, 1, high in GAP or RUN.
- done, out, 1, 1-cycle pulse when the last layer completes.
- error, out, 1, sticky watchdog error flag.
- run_cycles, out, 32, cycles from accepted start to done; frozen after done.

Behaviour:
- Reset (rst sampled high at an edge) takes effect on that edge:
  - state=IDLE, layer_en=0, buf_sel=0, cur_layer=0.
  - busy=0, done=0, error=0, run_cycles=0, watchdog=0.
- States are IDLE, GAP, RUN, FIN, ERR. All outputs are registered.
- IDLE:
  - start=1 and abort=0 -> GAP.
  - On the same edge: cur_layer=0, buf_sel=0, error=0, run_cycles=0, gap_cnt=0.
- GAP:
  - layer_en=0; gap_cnt increments each cycle.
  - When gap_cnt==IDLE_GAP-1 -> RUN, set layer_en[cur_layer]=1, clear watchdog.
  - Result: the enable is visible IDLE_GAP+1 cycles after the edge that accepted start.
- RUN:
  - layer_en[cur_layer] stays high; watchdog increments.
  - layer_done is ignored in the first RUN cycle, because the engine flag may be stale.
  - Only bit cur_layer is observed; other bits are ignored.
- On the first sampled layer_done[cur_layer]=1 (from the second RUN cycle on):
  - layer_en <= 0.
  - If cur_layer==NUM_LAYERS-1 -> FIN.
  - Otherwise cur_layer+1, buf_sel toggles, gap_cnt=0 -> GAP.
- If the watchdog reaches TIMEOUT with no done -> ERR, layer_en <= 0. Done wins if it arrives on the same cycle the watchdog reaches TIMEOUT.
- FIN: done=1 for exactly one cycle, then -> IDLE. run_cycles, buf_sel and cur_layer hold their final values.
- ERR: error=1 (sticky), busy=0, layer_en=0. Leaves to IDLE on abort; error stays set until the next accepted start.
- run_cycles increments every cycle busy=1 and saturates at all-ones.
- abort=1 in any state:
  - Next state is IDLE, layer_en <= 0, busy <= 0, with no done pulse.
  - cur_layer, buf_sel and run_cycles hold.
  - abort has priority over start, done and timeout.
- start while not in IDLE is ignored. start and rst on the same edge: rst wins.
- Invariant: popcount(layer_en) <= 1 at all times. layer_en is never high in consecutive layers without at least IDLE_GAP zero cycles between them.

Decomposition:
- Package n4_seq_pkg holds:
  - the state enum (IDLE, GAP, RUN, FIN, ERR);
  - the cur_layer width constant (4);
  - the run_cycles width constant (32).
- One sub-module, n4_watchdog. It is a TO_W-bit counter with clear and enable inputs and an expired output that is high when count==TIMEOUT. It is instantiated once and reused across layers.

Test Plan:
- NUM_LAYERS=4, IDLE_GAP=2; start at cycle 0; each layer raises done 10 cycles after its enable rises:
  - layer_en sequence 0001, 0010, 0100, 1000, each high for 11 cycles with 2 zero cycles between;
  - buf_sel 0,1,0,1;
  - done pulses once;
  - run_cycles=52.
- layer_done[3] held high throughout layer 0 -> ignored; layer 0 finishes only on its own done bit.
- layer_done[0] already high on the first RUN cycle and dropping after it -> ignored; layer stays enabled until a later done.
- TIMEOUT=20, layer 1 never finishes -> layer_en=0 and error=1 on the 21st enabled cycle, busy=0; abort -> IDLE with error still 1; a new start clears error.
- abort during GAP before layer 2 -> next cycle layer_en=0, busy=0, no done; cur_layer=2 and buf_sel=0 hold.
- start pulsed during RUN -> ignored. rst mid-layer -> every output at its reset value on the next cycle.

Source files
------------

// File: rtl/n4_seq_pkg.sv
// Shared types and widths for the n4 layer sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package n4_seq_pkg;

  // Width of the cur_layer index (covers up to 15 layers).
  localparam int CUR_W = 4;

  // Width of the run_cycles counter.
  localparam int RUN_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_RUN  = 3'd2,
    S_FIN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/n4_watchdog.sv
// Per-layer watchdog: counts enabled cycles and flags when the count hits TIMEOUT.
// Latency: o_expired follows the registered count combinationally.
// Backpressure: none; the count holds at TIMEOUT until cleared.
//
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_clr         - clears the count (has priority over i_en)
//   i_en          - advance the count by one
//   o_expired     - high while count == TIMEOUT
module n4_watchdog #(
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] r_count;

  // Stops at LIMIT so a stalled layer cannot wrap back below the threshold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/n4_layer_sequencer.sv
// Runs NUM_LAYERS layer engines in order with a clear gap, ping-pong bank select and watchdog.
// Latency: first enable appears IDLE_GAP edges after the edge accepting start; all outputs registered.
// Backpressure: waits on each engine's done flag; abort forces IDLE, timeout parks in ERR.
//
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_start          - one-cycle run request, accepted only in IDLE
//   i_abort          - level, returns to IDLE from any state
//   i_layer_done     - per-layer work-finished flags
//   o_layer_en       - one-hot (or zero) layer enables
//   o_buf_sel        - activation bank read by the current layer
//   o_cur_layer      - index of the layer in progress
//   o_busy           - high in GAP or RUN
//   o_done           - one-cycle pulse after the last layer completes
//   o_error          - sticky watchdog error
//   o_run_cycles     - busy cycles since accepted start, saturating
module n4_layer_sequencer
  import n4_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int IDLE_GAP   = 2,
  parameter int TIMEOUT    = 65535,
  parameter int TO_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NUM_LAYERS-1:0] i_layer_done,
  output logic [NUM_LAYERS-1:0] o_layer_en,
  output logic                  o_buf_sel,
  output logic [CUR_W-1:0]      o_cur_layer,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [RUN_W-1:0]      o_run_cycles
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(IDLE_GAP - 1);
  localparam logic [CUR_W-1:0]      LAST_IDX  = CUR_W'(NUM_LAYERS - 1);
  localparam logic [NUM_LAYERS-1:0] ONE_HOT0  = NUM_LAYERS'(1);
  localparam logic [RUN_W-1:0]      RUN_MAX   = '1;

  state_t                  r_state, w_state_nxt;
  logic [NUM_LAYERS-1:0]   r_layer_en, w_layer_en_nxt;
  logic                    r_buf_sel, w_buf_sel_nxt;
  logic [CUR_W-1:0]        r_cur_layer, w_cur_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_error, w_error_nxt;
  logic [RUN_W-1:0]        r_run_cycles, w_run_nxt;
  logic [GAP_W-1:0]        r_gap_cnt, w_gap_nxt;
  logic                    r_first, w_first_nxt;

  logic [NUM_LAYERS-1:0]   w_cur_onehot;
  logic                    w_sel_done;
  logic                    w_wd_expired;

  // Only the current layer's done bit matters; the others are masked off.
  assign w_cur_onehot = ONE_HOT0 << r_cur_layer;
  assign w_sel_done   = |(i_layer_done & w_cur_onehot);

  // Held clear outside RUN, so each layer starts counting from zero.
  n4_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (r_state != S_RUN),
    .i_en      (r_state == S_RUN),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_layer_en   <= '0;
      r_buf_sel    <= 1'b0;
      r_cur_layer  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_run_cycles <= '0;
      r_gap_cnt    <= '0;
      r_first      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_layer_en   <= w_layer_en_nxt;
      r_buf_sel    <= w_buf_sel_nxt;
      r_cur_layer  <= w_cur_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_run_cycles <= w_run_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_first      <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_layer_en_nxt = r_layer_en;
    w_buf_sel_nxt  = r_buf_sel;
    w_cur_nxt      = r_cur_layer;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_error_nxt    = r_error;
    w_run_nxt      = r_run_cycles;
    w_gap_nxt      = r_gap_cnt;
    w_first_nxt    = 1'b0;

    if (r_busy && (r_run_cycles != RUN_MAX)) begin
      w_run_nxt = r_run_cycles + RUN_W'(1);
    end

    if (i_abort) begin
      // Abort freezes progress counters and indices where they are.
      w_state_nxt    = S_IDLE;
      w_layer_en_nxt = '0;
      w_busy_nxt     = 1'b0;
      w_run_nxt      = r_run_cycles;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_nxt    = S_GAP;
            w_cur_nxt      = '0;
            w_buf_sel_nxt  = 1'b0;
            w_error_nxt    = 1'b0;
            w_run_nxt      = '0;
            w_gap_nxt      = '0;
            w_busy_nxt     = 1'b1;
            w_layer_en_nxt = '0;
          end
        end
        S_GAP: begin
          w_layer_en_nxt = '0;
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt    = S_RUN;
            w_layer_en_nxt = w_cur_onehot;
            w_first_nxt    = 1'b1;
          end else begin
            w_gap_nxt = r_gap_cnt + GAP_W'(1);
          end
        end
        S_RUN: begin
          // The engine's flag may still be stale in the first RUN cycle.
          // A done on the expiry cycle still counts as a completion.
          if (!r_first && w_sel_done) begin
            w_layer_en_nxt = '0;
            if (r_cur_layer == LAST_IDX) begin
              w_state_nxt = S_FIN;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end else begin
              w_state_nxt   = S_GAP;
              w_cur_nxt     = r_cur_layer + CUR_W'(1);
              w_buf_sel_nxt = ~r_buf_sel;
              w_gap_nxt     = '0;
            end
          end else if (w_wd_expired) begin
            w_state_nxt    = S_ERR;
            w_layer_en_nxt = '0;
            w_busy_nxt     = 1'b0;
            w_error_nxt    = 1'b1;
          end
        end
        S_FIN: begin
          w_state_nxt = S_IDLE;
        end
        S_ERR: begin
          // Parked until abort.
          w_layer_en_nxt = '0;
          w_busy_nxt     = 1'b0;
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_layer_en_nxt = '0;
          w_busy_nxt     = 1'b0;
        end
      endcase
    end
  end

  assign o_layer_en   = r_layer_en;
  assign o_buf_sel    = r_buf_sel;
  assign o_cur_layer  = r_cur_layer;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_run_cycles = r_run_cycles;

endmodule

// File: tb/tb_n4_layer_sequencer.sv
`timescale 1ns/1ps
module tb_n4_layer_sequencer;

  localparam int NL  = 4;
  localparam int GAP = 2;
  localparam int TO  = 20;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] o_layer_en;
  logic          o_buf_sel;
  logic [3:0]    o_cur_layer;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [31:0]   o_run_cycles;

  n4_layer_sequencer #(
    .NUM_LAYERS (NL),
    .IDLE_GAP   (GAP),
    .TIMEOUT    (TO),
    .TO_W       (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_layer_done (layer_done),
    .o_layer_en   (o_layer_en),
    .o_buf_sel    (o_buf_sel),
    .o_cur_layer  (o_cur_layer),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_run_cycles (o_run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- engine stand-ins ----------------
  int           lat [NL];      // done rises lat cycles after enable rises; 0 = never
  int           eng_age [NL];
  logic [NL-1:0] eng_done;
  logic [NL-1:0] extra_done;   // stray/stale flag injection
  assign layer_done = eng_done | extra_done;

  initial begin
    for (int i = 0; i < NL; i++) begin
      eng_age[i] = 0;
      lat[i]     = 10;
    end
    eng_done = '0;
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NL; i++) begin
      if (o_layer_en[i] === 1'b1) eng_age[i]++;
      else eng_age[i] = 0;
      eng_done[i] = (lat[i] != 0) && (eng_age[i] >= lat[i] + 1);
    end
  end

  // ---------------- behavioural model ----------------
  // Tracks the expected outputs via countdowns: zero cycles still owed
  // before the next enable, and how many cycles the current layer has run.
  int     e_en;
  bit     e_buf;
  int     e_cur;
  bit     e_busy, e_done, e_err;
  longint e_run;
  int     gap_left, age;
  bit     err_hold, m_idle;

  initial begin
    e_en = 0; e_buf = 0; e_cur = 0; e_busy = 0; e_done = 0; e_err = 0;
    e_run = 0; gap_left = 0; age = 0; err_hold = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      e_en = 0; e_buf = 0; e_cur = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_run = 0; gap_left = 0; age = 0; err_hold = 0;
    end else if (abort) begin
      e_en = 0; e_busy = 0; e_done = 0; gap_left = 0; age = 0; err_hold = 0;
    end else begin
      m_idle = !e_busy && !err_hold && !e_done;
      e_done = 0;
      if (e_busy && e_run != 64'h0000_0000_FFFF_FFFF) e_run++;
      if (m_idle && start) begin
        e_busy = 1; e_cur = 0; e_buf = 0; e_err = 0; e_run = 0;
        e_en = 0; gap_left = GAP;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin
          e_en = 1 << e_cur;
          age  = 1;
        end
      end else if (age > 0) begin
        if (age >= 2 && layer_done[e_cur]) begin
          e_en = 0; age = 0;
          if (e_cur == NL - 1) begin
            e_busy = 0; e_done = 1;
          end else begin
            e_cur++; e_buf = !e_buf; gap_left = GAP;
          end
        end else if (age >= TO + 1) begin
          e_en = 0; age = 0; e_busy = 0; e_err = 1; err_hold = 1;
        end else begin
          age++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (o_done === 1'b1) done_cnt++;
    if (chk_en) begin
      chk("layer_en",   o_layer_en,   e_en);
      chk("buf_sel",    o_buf_sel,    e_buf);
      chk("cur_layer",  o_cur_layer,  e_cur);
      chk("busy",       o_busy,       e_busy);
      chk("done",       o_done,       e_done);
      chk("error",      o_error,      e_err);
      chk("run_cycles", o_run_cycles, e_run);
      chk("en_onehot",  ($countones(o_layer_en) <= 1) ? 1 : 0, 1);
    end
  end

  // ---------------- directed stimulus ----------------
  longint t0;

  // Cycle k is the k-th cycle after the edge that accepted start.
  task automatic goto(input int k, input int off);
    longint tgt;
    tgt = t0 + 10 * (k - 1) + off;
    if (tgt > $time) #(tgt - $time);
  endtask

  task automatic start_run();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
    #2;
    start = 1'b0;
  endtask

  task automatic pulse_abort(input int k);
    goto(k, 2); abort = 1'b1;
    goto(k + 1, 2); abort = 1'b0;
  endtask

  int d0;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; extra_done = '0; t0 = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_layer_en", o_layer_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_run", o_run_cycles, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // 1) Full four-layer run, each engine done 10 cycles after enable.
    d0 = done_cnt;
    start_run();
    goto(2, 5);  chk("t1_gap_en", o_layer_en, 0);
    goto(3, 5);  chk("t1_l0_en", o_layer_en, 4'b0001); chk("t1_l0_buf", o_buf_sel, 0);
    goto(13, 5); chk("t1_l0_last", o_layer_en, 4'b0001);
    goto(14, 5); chk("t1_l0_off", o_layer_en, 0);
    goto(16, 5); chk("t1_l1_en", o_layer_en, 4'b0010); chk("t1_l1_buf", o_buf_sel, 1);
    goto(29, 5); chk("t1_l2_en", o_layer_en, 4'b0100); chk("t1_l2_buf", o_buf_sel, 0);
    goto(42, 5); chk("t1_l3_en", o_layer_en, 4'b1000); chk("t1_l3_buf", o_buf_sel, 1);
    goto(53, 5); chk("t1_done", o_done, 1); chk("t1_run", o_run_cycles, 52);
    goto(56, 7); chk("t1_done_pulses", done_cnt - d0, 1); chk("t1_run_frozen", o_run_cycles, 52);

    // 2) Stray done bit from layer 3 during layer 0 is ignored.
    extra_done = 4'b1000;
    start_run();
    goto(4, 5);  chk("t2_l0_held", o_layer_en, 4'b0001);
    goto(13, 5); chk("t2_l0_last", o_layer_en, 4'b0001);
    goto(14, 2); extra_done = '0;
    goto(16, 5); chk("t2_l1_en", o_layer_en, 4'b0010);
    goto(56, 5);

    // 3) Stale done on the first RUN cycle is ignored.
    lat[0] = 5;
    start_run();
    goto(3, 2); extra_done = 4'b0001;
    goto(4, 2); extra_done = '0;
    goto(4, 5); chk("t3_stale_ignored", o_layer_en, 4'b0001);
    goto(8, 5); chk("t3_l0_last", o_layer_en, 4'b0001);
    goto(9, 5); chk("t3_l0_off", o_layer_en, 0);
    pulse_abort(9);
    goto(12, 5);
    lat[0] = 10;

    // 4) Watchdog: layer 1 never finishes.
    lat[1] = 0;
    start_run();
    goto(36, 5); chk("t4_still_en", o_layer_en, 4'b0010); chk("t4_no_err_yet", o_error, 0);
    goto(37, 5); chk("t4_en_off", o_layer_en, 0); chk("t4_err", o_error, 1);
    chk("t4_busy", o_busy, 0); chk("t4_run", o_run_cycles, 36);
    goto(38, 2); start = 1'b1;
    goto(39, 2); start = 1'b0;
    goto(39, 5); chk("t4_start_in_err", o_busy, 0);
    pulse_abort(40);
    goto(41, 5); chk("t4_err_sticky", o_error, 1); chk("t4_abort_idle", o_busy, 0);
    start_run();
    goto(1, 5); chk("t4_err_cleared", o_error, 0); chk("t4_restart_busy", o_busy, 1);
    pulse_abort(3);
    goto(6, 5);
    lat[1] = 10;

    // 5) Abort in the gap before layer 2.
    d0 = done_cnt;
    start_run();
    pulse_abort(27);
    goto(28, 5); chk("t5_en", o_layer_en, 0); chk("t5_busy", o_busy, 0);
    chk("t5_cur", o_cur_layer, 2); chk("t5_buf", o_buf_sel, 0); chk("t5_run", o_run_cycles, 26);
    goto(60, 7); chk("t5_no_done", done_cnt - d0, 0);

    // 6) Start during RUN ignored, then reset mid-layer.
    start_run();
    goto(18, 2); start = 1'b1;
    goto(19, 2); start = 1'b0;
    goto(19, 5); chk("t6_start_ignored", o_layer_en, 4'b0010);
    chk("t6_cur", o_cur_layer, 1); chk("t6_run", o_run_cycles, 18);
    goto(20, 2); rst = 1'b1;
    goto(21, 2); rst = 1'b0;
    goto(21, 5);
    chk("t6_rst_en", o_layer_en, 0); chk("t6_rst_cur", o_cur_layer, 0);
    chk("t6_rst_buf", o_buf_sel, 0); chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_run", o_run_cycles, 0); chk("t6_rst_err", o_error, 0);
    goto(24, 5);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
